// File: rtl/mem_server_latency_pkg.sv
// Shared memory-interface definitions: op/len encodings, default-width message
// structs and the byte-lane helpers used by word-array responders.
package mem_server_latency_pkg;

  typedef enum logic {
    MEM_OP_RD = 1'b0,
    MEM_OP_WR = 1'b1
  } mem_op_t;

  typedef enum logic [1:0] {
    MEM_LEN_4B = 2'd0,
    MEM_LEN_1B = 2'd1,
    MEM_LEN_2B = 2'd2
  } mem_len_t;

  localparam int MEM_DEF_OPAQ_BITS = 8;
  localparam int MEM_DEF_ADDR_BITS = 32;

  // Default-width messages; responders with other widths rebuild these locally.
  typedef struct packed {
    mem_op_t                       op;
    logic [MEM_DEF_OPAQ_BITS-1:0]  opaque;
    logic [MEM_DEF_ADDR_BITS-1:0]  addr;
    mem_len_t                      len;
    logic [31:0]                   data;
  } mem_req_t;

  typedef mem_req_t mem_resp_t;

  // Misaligned accesses fall back to the aligned-down lane.
  function automatic logic [4:0] lane_shift(input logic [1:0] len, input logic [1:0] off);
    case (len)
      MEM_LEN_1B: return {off, 3'b000};
      MEM_LEN_2B: return {off[1], 4'b0000};
      default:    return 5'd0;
    endcase
  endfunction

  function automatic logic [31:0] len_mask(input logic [1:0] len);
    case (len)
      MEM_LEN_1B: return 32'h0000_00ff;
      MEM_LEN_2B: return 32'h0000_ffff;
      default:    return 32'hffff_ffff;
    endcase
  endfunction

endpackage

// File: rtl/mem_resp_fifo.sv
// Circular response buffer with wrap-around head/tail pointers and an entry count.
// Enqueue into a full buffer is legal only together with a dequeue.
module mem_resp_fifo #(
  parameter int  p_depth = 4,
  parameter type t_msg   = logic [31:0]
) (
  input  logic clk,
  input  logic rst,
  input  logic enq_val,
  input  t_msg enq_msg,
  output logic deq_val,
  input  logic deq_rdy,
  output t_msg deq_msg
);

  localparam int PTR_W = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam int CNT_W = $clog2(p_depth + 1);

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             val_q, val_d;
  logic             do_enq_s, do_deq_s, full_s;
  t_msg             buf_q [p_depth];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(p_depth - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Pointer and occupancy next-state.
  always_comb begin
    full_s   = (count_q == CNT_W'(p_depth));
    do_deq_s = val_q && deq_rdy;
    do_enq_s = enq_val && (!full_s || do_deq_s);
    head_d   = do_deq_s ? ptr_inc(head_q) : head_q;
    tail_d   = do_enq_s ? ptr_inc(tail_q) : tail_q;
    if (do_enq_s && !do_deq_s) begin
      count_d = count_q + CNT_W'(1);
    end else if (!do_enq_s && do_deq_s) begin
      count_d = count_q - CNT_W'(1);
    end else begin
      count_d = count_q;
    end
    val_d = (count_d != {CNT_W{1'b0}});
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= {PTR_W{1'b0}};
      tail_q  <= {PTR_W{1'b0}};
      count_q <= {CNT_W{1'b0}};
      val_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      val_q   <= val_d;
    end
  end

  // Entry storage; contents are qualified by the count, so no reset.
  always_ff @(posedge clk) begin
    if (do_enq_s) begin
      buf_q[tail_q] <= enq_msg;
    end
  end

  assign deq_val = val_q;
  assign deq_msg = buf_q[head_q];

endmodule

// File: rtl/mem_server_latency.sv
// Fixed-latency, in-order word-array memory responder with credit-based req_rdy:
// every accepted request already owns a slot in the response buffer.
module mem_server_latency
  import mem_server_latency_pkg::*;
#(
  parameter int p_opaq_bits  = 8,
  parameter int p_addr_bits  = 32,
  parameter int p_mem_words  = 4096,
  parameter int p_latency    = 2,
  parameter int p_resp_depth = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_req_val,
  output logic                   mem_req_rdy,
  input  logic                   mem_req_op,
  input  logic [p_opaq_bits-1:0] mem_req_opaque,
  input  logic [p_addr_bits-1:0] mem_req_addr,
  input  logic [1:0]             mem_req_len,
  input  logic [31:0]            mem_req_data,
  output logic                   mem_resp_val,
  input  logic                   mem_resp_rdy,
  output logic                   mem_resp_op,
  output logic [p_opaq_bits-1:0] mem_resp_opaque,
  output logic [p_addr_bits-1:0] mem_resp_addr,
  output logic [1:0]             mem_resp_len,
  output logic [31:0]            mem_resp_data
);

  localparam int IDX_W  = $clog2(p_mem_words);
  localparam int CNT_W  = $clog2(p_resp_depth + 1);
  localparam int STAGES = p_latency - 1;

  typedef struct packed {
    logic                   op;
    logic [p_opaq_bits-1:0] opaque;
    logic [p_addr_bits-1:0] addr;
    logic [1:0]             len;
    logic [31:0]            data;
  } resp_t;

  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic             req_rdy_q, req_rdy_d;
  logic             acc_s, deq_s, enq_val_s, fifo_val_s;
  logic [IDX_W-1:0] idx_s;
  logic [4:0]       shamt_s;
  logic [31:0]      bmask_s, wdata_s, rdata_s;
  logic [31:0]      mem_q [p_mem_words];
  resp_t            acc_msg_s, enq_msg_s, head_s;

  // Lane alignment and response message for the request being accepted.
  always_comb begin
    idx_s   = mem_req_addr[IDX_W+1:2];
    shamt_s = lane_shift(mem_req_len, mem_req_addr[1:0]);
    bmask_s = len_mask(mem_req_len) << shamt_s;
    wdata_s = (mem_req_data & len_mask(mem_req_len)) << shamt_s;
    rdata_s = (mem_q[idx_s] >> shamt_s) & len_mask(mem_req_len);
    acc_s   = mem_req_val && req_rdy_q;
    deq_s   = fifo_val_s && mem_resp_rdy;
    acc_msg_s.op     = mem_req_op;
    acc_msg_s.opaque = mem_req_opaque;
    acc_msg_s.addr   = mem_req_addr;
    acc_msg_s.len    = mem_req_len;
    acc_msg_s.data   = (mem_req_op == MEM_OP_WR) ? 32'd0 : rdata_s;
  end

  // Credits: ready only depends on registered occupancy, never on req_val.
  always_comb begin
    if (acc_s && !deq_s) begin
      inflight_d = inflight_q + CNT_W'(1);
    end else if (!acc_s && deq_s) begin
      inflight_d = inflight_q - CNT_W'(1);
    end else begin
      inflight_d = inflight_q;
    end
    req_rdy_d = (inflight_d < CNT_W'(p_resp_depth));
  end

  // Credit counter and registered ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_q <= {CNT_W{1'b0}};
      req_rdy_q  <= 1'b1;
    end else begin
      inflight_q <= inflight_d;
      req_rdy_q  <= req_rdy_d;
    end
  end

  // Array write lands at the accept edge, so a following read sees it.
  always_ff @(posedge clk) begin
    if (acc_s && (mem_req_op == MEM_OP_WR)) begin
      mem_q[idx_s] <= (mem_q[idx_s] & ~bmask_s) | (wdata_s & bmask_s);
    end
  end

  generate
    if (STAGES == 0) begin : g_direct
      assign enq_val_s = acc_s;
      assign enq_msg_s = acc_msg_s;
    end else begin : g_pipe
      logic [STAGES-1:0] val_q, val_d;
      resp_t             msg_q [STAGES];
      resp_t             msg_d [STAGES];

      // Free-running delay line; the credit rule guarantees buffer space at the end.
      always_comb begin
        val_d    = val_q;
        val_d[0] = acc_s;
        msg_d[0] = acc_msg_s;
        for (int i = 1; i < STAGES; i++) begin
          val_d[i] = val_q[i-1];
          msg_d[i] = msg_q[i-1];
        end
      end

      // Stage valids.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          val_q <= {STAGES{1'b0}};
        end else begin
          val_q <= val_d;
        end
      end

      // Stage payloads, qualified by the valids.
      always_ff @(posedge clk) begin
        for (int i = 0; i < STAGES; i++) begin
          msg_q[i] <= msg_d[i];
        end
      end

      assign enq_val_s = val_q[STAGES-1];
      assign enq_msg_s = msg_q[STAGES-1];
    end
  endgenerate

  mem_resp_fifo #(
    .p_depth (p_resp_depth),
    .t_msg   (resp_t)
  ) u_resp_fifo (
    .clk     (clk),
    .rst     (rst),
    .enq_val (enq_val_s),
    .enq_msg (enq_msg_s),
    .deq_val (fifo_val_s),
    .deq_rdy (mem_resp_rdy),
    .deq_msg (head_s)
  );

  assign mem_req_rdy     = req_rdy_q;
  assign mem_resp_val    = fifo_val_s;
  assign mem_resp_op     = head_s.op;
  assign mem_resp_opaque = head_s.opaque;
  assign mem_resp_addr   = head_s.addr;
  assign mem_resp_len    = head_s.len;
  assign mem_resp_data   = head_s.data;

endmodule

// File: tb/tb_mem_server_latency.sv
// Directed bench for mem_server_latency: reset, latency, byte lanes,
// credit backpressure, full-rate throughput and mid-flight reset.
module tb_mem_server_latency;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_val = 1'b0;
  logic        req_rdy;
  logic        req_op = 1'b0;
  logic [7:0]  req_opq = 8'h00;
  logic [31:0] req_addr = 32'h0;
  logic [1:0]  req_len = 2'd0;
  logic [31:0] req_data = 32'h0;
  logic        resp_val;
  logic        resp_rdy = 1'b1;
  logic        resp_op;
  logic [7:0]  resp_opq;
  logic [31:0] resp_addr;
  logic [1:0]  resp_len;
  logic [31:0] resp_data;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int          cyc;
    logic        op;
    logic [7:0]  opq;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } rsp_t;

  rsp_t rsp_q[$];
  int   acc_q[$];

  mem_server_latency dut (
    .clk             (clk),
    .rst             (rst),
    .mem_req_val     (req_val),
    .mem_req_rdy     (req_rdy),
    .mem_req_op      (req_op),
    .mem_req_opaque  (req_opq),
    .mem_req_addr    (req_addr),
    .mem_req_len     (req_len),
    .mem_req_data    (req_data),
    .mem_resp_val    (resp_val),
    .mem_resp_rdy    (resp_rdy),
    .mem_resp_op     (resp_op),
    .mem_resp_opaque (resp_opq),
    .mem_resp_addr   (resp_addr),
    .mem_resp_len    (resp_len),
    .mem_resp_data   (resp_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record handshakes that will fire at the coming rising edge.
  always @(negedge clk) begin
    if (rst && req_val && req_rdy) acc_q.push_back(cyc);
    if (rst && resp_val && resp_rdy)
      rsp_q.push_back('{cyc, resp_op, resp_opq, resp_addr, resp_len, resp_data});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic op, input logic [7:0] opq, input logic [31:0] addr,
                       input logic [1:0] len, input logic [31:0] data);
    bit done = 1'b0;
    req_op = op; req_opq = opq; req_addr = addr; req_len = len; req_data = data;
    req_val = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (req_rdy) done = 1'b1;
      @(posedge clk); #1;
    end
    req_val = 1'b0;
    if (!done) check("issue_timeout", 32'(done), 32'd1);
  endtask

  task automatic get_rsp(input string tag, output rsp_t r);
    r = '{0, 1'b0, 8'h00, 32'h0, 2'd0, 32'h0};
    for (int i = 0; i < 100 && rsp_q.size() == 0; i++) begin
      @(posedge clk); #1;
    end
    if (rsp_q.size() > 0) r = rsp_q.pop_front();
    else check({tag, "_timeout"}, 32'(rsp_q.size()), 32'd1);
  endtask

  function automatic int first_acc();
    return (acc_q.size() > 0) ? acc_q[0] : -1000;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rsp_t r;
    int   t0;
    int   last;

    // Bring-up and preload of word 0x10 through a normal write.
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    issue(1'b1, 8'h00, 32'h40, 2'd0, 32'hdeadbeef);
    get_rsp("preload", r);

    // 1. Reset held low for three cycles.
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_resp_val", 32'(resp_val), 32'd0);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("post_rst_req_rdy", 32'(req_rdy), 32'd1);
    check("post_rst_resp_val", 32'(resp_val), 32'd0);
    @(posedge clk); #1;

    // 2. Read latency; the preloaded word survives reset.
    acc_q.delete(); rsp_q.delete();
    issue(1'b0, 8'h5a, 32'h40, 2'd0, 32'h0);
    t0 = first_acc();
    get_rsp("lat", r);
    check("lat_cycles", 32'(r.cyc - t0), 32'd2);
    check("lat_data", r.data, 32'hdeadbeef);
    check("lat_opq", 32'(r.opq), 32'h5a);

    // 3. Byte write then word and halfword reads.
    issue(1'b1, 8'h01, 32'h41, 2'd1, 32'h0000_00aa);
    get_rsp("wr_b", r);
    check("wr_b_op", 32'(r.op), 32'd1);
    check("wr_b_data", r.data, 32'h0);
    issue(1'b0, 8'h02, 32'h40, 2'd0, 32'h0);
    get_rsp("rd_w", r);
    check("rd_w_data", r.data, 32'hdeadaaef);
    issue(1'b0, 8'h03, 32'h42, 2'd2, 32'h0);
    get_rsp("rd_h", r);
    check("rd_h_data", r.data, 32'h0000dead);
    check("rd_h_addr", r.addr, 32'h42);
    check("rd_h_len", 32'(r.len), 32'd2);

    // 4. Backpressure: six reads against four credits.
    acc_q.delete(); rsp_q.delete();
    resp_rdy = 1'b0;
    fork
      for (int i = 0; i < 6; i++) issue(1'b0, 8'(8'h10 + i), 32'h40, 2'd0, 32'h0);
      begin
        repeat (8) @(posedge clk);
        #1;
        check("bp_accepted", 32'(acc_q.size()), 32'd4);
        @(negedge clk);
        check("bp_req_rdy", 32'(req_rdy), 32'd0);
        check("bp_resp_val", 32'(resp_val), 32'd1);
        resp_rdy = 1'b1;
      end
    join
    for (int i = 0; i < 6; i++) begin
      get_rsp("bp", r);
      check("bp_opq", 32'(r.opq), 32'(8'h10 + i));
      check("bp_data", r.data, 32'hdeadaaef);
    end
    check("bp_total_acc", 32'(acc_q.size()), 32'd6);

    // 5. Full-rate throughput.
    acc_q.delete(); rsp_q.delete();
    for (int i = 0; i < 32; i++) issue(1'b0, 8'(i), 32'h40, 2'd0, 32'h0);
    check("tput_acc_cnt", 32'(acc_q.size()), 32'd32);
    t0 = first_acc();
    check("tput_acc_span", 32'((acc_q.size() > 0 ? acc_q[acc_q.size()-1] : 0) - t0), 32'd31);
    last = 0;
    for (int i = 0; i < 32; i++) begin
      get_rsp("tput", r);
      check("tput_opq", 32'(r.opq), 32'(i));
      last = r.cyc;
    end
    check("tput_span", 32'(last - t0), 32'd33);

    // 6. Reset with three requests in flight.
    acc_q.delete(); rsp_q.delete();
    resp_rdy = 1'b0;
    for (int i = 0; i < 3; i++) issue(1'b0, 8'(8'h70 + i), 32'h40, 2'd0, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_resp_val", 32'(resp_val), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    resp_rdy = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("mid_rst_no_rsp", 32'(rsp_q.size()), 32'd0);
    check("mid_rst_inflight", 32'(dut.inflight_q), 32'd0);
    acc_q.delete();
    issue(1'b0, 8'h80, 32'h40, 2'd0, 32'h0);
    t0 = first_acc();
    get_rsp("mid_rst_new", r);
    check("mid_rst_new_lat", 32'(r.cyc - t0), 32'd2);
    check("mid_rst_new_opq", 32'(r.opq), 32'h80);
    check("mid_rst_new_data", r.data, 32'hdeadaaef);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
